freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures the frequency of a slow, asynchronous input signal, such as the output of a clock divider, by counting its rising edges over a fixed gate window of `clk` cycles.
- Reports the edge count together with a one-cycle valid strobe.
- Used on board to check divided clocks and external test signals.
- Supports single-shot and continuous (back-to-back window) operation.

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in `clk` cycles; must be ≥ 2. At 50 MHz the default is a 1 s gate, so the count is in Hz.
- CNT_W, 32, width of the edge counter and of the result.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  signal under measurement; asynchronous to `clk`.
- start  input  1  single-cycle request to begin a measurement; ignored while `busy`=1.
- cont  input  1  continuous mode; when 1, a new window begins immediately after each result.
- freq_cnt  output  CNT_W  rising-edge count of the last completed window.
- cnt_valid  output  1  one-cycle strobe; `freq_cnt` and `overflow` are updated in the same cycle.
- overflow  output  1  1 when the last window's count saturated.
- busy  output  1  1 while a gate window is open.

Behaviour:
- Clock and reset: `clk` is the clock. `rst_n` is an asynchronous, active-low reset.
- Reset values: all outputs 0, synchronizer flops 0, FSM in IDLE, all counters 0.
- Input synchronizer: `sig_in` passes through 2 flops (s1, s2) plus a delay flop s3.
  - edge_p = s2 & ~s3.
  - edge_p asserts 3 `clk` edges after a `sig_in` rise (worst case).
  - Supported input frequency is below clk/2 (high and low phases each ≥ 1 `clk` period). Faster inputs give undefined counts.
- FSM has two states: IDLE and GATE.
- IDLE:
  - `busy`=0.
  - When `start`=1, go to GATE on the next edge.
  - On entry to GATE: gate_cnt ← GATE_CYCLES-1, edge_cnt ← 0, ovf_int ← 0.
- GATE (`busy`=1):
  - Every cycle with edge_p=1, edge_cnt increments.
  - If edge_cnt is already all-ones, it holds and ovf_int ← 1 (saturating count).
  - gate_cnt decrements every cycle.
  - The window is exactly GATE_CYCLES cycles, including the terminal cycle where gate_cnt==0.
- Terminal cycle (gate_cnt==0), registered at the next edge:
  - `freq_cnt` ← edge_cnt + edge_p, saturating. An edge_p in the terminal cycle is counted in the closing window.
  - `overflow` ← ovf_int, or 1 if the terminal increment saturates.
  - `cnt_valid` ← 1 for exactly one cycle.
  - If `cont`=1: stay in GATE. gate_cnt reloads to GATE_CYCLES-1 and edge_cnt/ovf_int clear in the same edge, so there are no dead cycles and no edge is counted in two windows.
  - If `cont`=0: return to IDLE.
- `start` while `busy`=1: ignored; it neither restarts nor extends the window.
- `cont` is sampled only in the terminal cycle. Deasserting it mid-window finishes the current window, then goes to IDLE.
- `freq_cnt` and `overflow` hold their value until the next `cnt_valid`; they are not cleared when a new window starts.
- Reset mid-window: the measurement is aborted immediately. Outputs go to their reset values and no `cnt_valid` is produced.
- Latency: `cnt_valid` asserts GATE_CYCLES+1 cycles after the cycle in which `start` was sampled.

Test Plan:
1. Divide-by-4 input: GATE_CYCLES=100, `sig_in` = clk/4 square wave running ≥ 10 cycles before `start`, single pulse on `start`. Expect one `cnt_valid` 101 cycles later, `freq_cnt`=25, `overflow`=0, `busy` high for exactly 100 cycles.
2. Static input: GATE_CYCLES=100, `sig_in` held 1 (then repeated with `sig_in` held 0). Expect `freq_cnt`=0 both times. A 0→1 step while `busy`=1 (at least 4 cycles before window end, so edge_p lands inside the window) gives `freq_cnt`=1.
3. Saturation: CNT_W=4, GATE_CYCLES=100, `sig_in` = clk/4. Expect `freq_cnt`=15, `overflow`=1. A following window with `sig_in` = clk/16 gives `freq_cnt`=6 or 7 (phase-dependent) and `overflow`=0.
4. Continuous mode: `cont`=1, GATE_CYCLES=100, `sig_in` = clk/8. Expect `cnt_valid` every 100 cycles, each `freq_cnt`=12 or 13, and the sum over 8 windows = 100 (no lost or double-counted edges). Then drop `cont`: exactly one more result, then `busy`=0.
5. Start while busy: a second `start` pulse 50 cycles into a window. Expect no restart, `cnt_valid` at the original time, and only one result.
6. Reset mid-window: assert `rst_n`=0 at cycle 40 of a window. Expect all outputs 0 immediately, no `cnt_valid`. After release, a new `start` measures normally and reproduces scenario 1's result.

Source files
------------

// File: rtl/freq_meter_if.sv
// freq_meter_if: measurement request/result bundle between a controller (master) and freq_meter (slave)
interface freq_meter_if #(parameter int CNT_W = 32);
  logic             sig_in;
  logic             start;
  logic             cont;
  logic [CNT_W-1:0] freq_cnt;
  logic             cnt_valid;
  logic             overflow;
  logic             busy;
  modport master (output sig_in, start, cont, input freq_cnt, cnt_valid, overflow, busy);
  modport slave  (input sig_in, start, cont, output freq_cnt, cnt_valid, overflow, busy);
endinterface

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a GATE_CYCLES window; ports clk, rst_n (async low), bus (sig_in/start/cont in, freq_cnt/cnt_valid/overflow/busy out)
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int CNT_W       = 32
) (
  input logic         clk,
  input logic         rst_n,
  freq_meter_if.slave bus
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  typedef enum logic {IDLE, GATE} state_t;
  state_t           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, edge_nxt, freq_cnt_q, freq_cnt_d;
  logic             ovf_q, ovf_d, ovf_nxt, overflow_q, overflow_d, cnt_valid_q, cnt_valid_d;
  logic             edge_p, full, term, reload;
  always_comb begin
    s_d         = {s_q[1:0], bus.sig_in};
    edge_p      = s_q[1] & ~s_q[2];
    full        = &edge_cnt_q;
    edge_nxt    = edge_cnt_q + CNT_W'(edge_p & ~full);
    ovf_nxt     = ovf_q | (edge_p & full);
    term        = (state_q == GATE) && (gate_cnt_q == '0);
    // a new window opens on start from IDLE, or back-to-back at the terminal cycle in continuous mode
    reload      = (state_q == IDLE) ? bus.start : (term & bus.cont);
    state_d     = (state_q == IDLE) ? (bus.start ? GATE : IDLE) : ((term && !bus.cont) ? IDLE : GATE);
    gate_cnt_d  = reload ? GATE_LAST : ((state_q == GATE && !term) ? gate_cnt_q - 1'b1 : gate_cnt_q);
    edge_cnt_d  = reload ? '0 : ((state_q == GATE) ? edge_nxt : edge_cnt_q);
    ovf_d       = reload ? 1'b0 : ((state_q == GATE) ? ovf_nxt : ovf_q);
    freq_cnt_d  = term ? edge_nxt : freq_cnt_q;
    overflow_d  = term ? ovf_nxt : overflow_q;
    cnt_valid_d = term;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      freq_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      cnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      freq_cnt_q  <= freq_cnt_d;
      overflow_q  <= overflow_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end
  assign bus.freq_cnt  = freq_cnt_q;
  assign bus.overflow  = overflow_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.busy      = (state_q == GATE);
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed checks of freq_meter with a 32-bit and a 4-bit (saturating) instance
module tb_freq_meter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lvl = 1'b0;
  int   div = 0;
  int   ph = 0;
  logic sig;
  logic start_a = 1'b0, start_b = 1'b0, cont_a = 1'b0;
  int   checks = 0, failures = 0;
  int   lat, busy_n, nval, nv, last, sum;
  logic [31:0] cnt;
  logic ovf;
  always #5 clk = ~clk;
  always @(negedge clk) ph <= (div == 0 || ph + 1 >= div) ? 0 : ph + 1;
  assign sig = (div == 0) ? lvl : (ph < div / 2);
  freq_meter_if #(.CNT_W(32)) ia ();
  freq_meter_if #(.CNT_W(4))  ib ();
  assign ia.sig_in = sig;
  assign ib.sig_in = sig;
  assign ia.start  = start_a;
  assign ib.start  = start_b;
  assign ia.cont   = cont_a;
  assign ib.cont   = 1'b0;
  freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  freq_meter #(.GATE_CYCLES(100), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask
  // pulse start on one instance and watch 120 cycles; ev_kind 1 = extra start at cycle ev_at, 2 = lvl rises at cycle ev_at
  task automatic measure(input bit b, input int ev_at, input int ev_kind, output int lat_o, output int busy_o,
                         output int nval_o, output logic [31:0] cnt_o, output logic ovf_o);
    lat_o = 0; busy_o = 0; nval_o = 0; cnt_o = '0; ovf_o = 1'b0;
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    for (int n = 1; n <= 120; n++) begin
      if (n == ev_at && ev_kind == 1) begin
        if (b) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (n == ev_at && ev_kind == 2) lvl = 1'b1;
      if (b ? ib.busy : ia.busy) busy_o++;
      if (b ? ib.cnt_valid : ia.cnt_valid) begin
        nval_o++;
        if (lat_o == 0) lat_o = n;
        cnt_o = b ? 32'(ib.freq_cnt) : ia.freq_cnt;
        ovf_o = b ? ib.overflow : ia.overflow;
      end
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_freq_a", ia.freq_cnt, 0);
    chk("rst_valid_a", ia.cnt_valid, 0);
    chk("rst_ovf_a", ia.overflow, 0);
    chk("rst_busy_a", ia.busy, 0);
    chk("rst_busy_b", ib.busy, 0);
    rst_n = 1'b1;
    div = 4;
    repeat (12) @(negedge clk);
    measure(0, 0, 0, lat, busy_n, nval, cnt, ovf);
    chk("div4_lat", lat, 101);
    chk("div4_busy", busy_n, 100);
    chk("div4_nval", nval, 1);
    chk("div4_cnt", cnt, 25);
    chk("div4_ovf", ovf, 0);
    chk("div4_hold", ia.freq_cnt, 25);
    div = 0; lvl = 1'b1;
    repeat (6) @(negedge clk);
    measure(0, 0, 0, lat, busy_n, nval, cnt, ovf);
    chk("static1_cnt", cnt, 0);
    chk("static1_nval", nval, 1);
    lvl = 1'b0;
    repeat (6) @(negedge clk);
    measure(0, 0, 0, lat, busy_n, nval, cnt, ovf);
    chk("static0_cnt", cnt, 0);
    measure(0, 20, 2, lat, busy_n, nval, cnt, ovf);
    chk("step_cnt", cnt, 1);
    chk("step_lat", lat, 101);
    div = 4;
    repeat (12) @(negedge clk);
    measure(1, 0, 0, lat, busy_n, nval, cnt, ovf);
    chk("sat_cnt", cnt, 15);
    chk("sat_ovf", ovf, 1);
    chk("sat_lat", lat, 101);
    div = 16;
    repeat (20) @(negedge clk);
    measure(1, 0, 0, lat, busy_n, nval, cnt, ovf);
    chk_rng("div16_cnt", cnt, 6, 7);
    chk("div16_ovf", ovf, 0);
    div = 8;
    repeat (12) @(negedge clk);
    cont_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    nv = 0; last = 0; sum = 0;
    for (int n = 1; n <= 1000; n++) begin
      if (ia.cnt_valid) begin
        nv++;
        chk("cont_interval", n - last, (nv == 1) ? 101 : 100);
        chk_rng("cont_cnt", ia.freq_cnt, 12, 13);
        if (nv <= 8) sum += int'(ia.freq_cnt);
        if (nv == 8) cont_a = 1'b0;
        last = n;
      end
      @(negedge clk);
    end
    chk("cont_sum8", sum, 100);
    chk("cont_nval", nv, 9);
    chk("cont_idle", ia.busy, 0);
    div = 4;
    repeat (12) @(negedge clk);
    measure(0, 50, 1, lat, busy_n, nval, cnt, ovf);
    chk("busy_start_lat", lat, 101);
    chk("busy_start_nval", nval, 1);
    chk("busy_start_busy", busy_n, 100);
    chk("busy_start_cnt", cnt, 25);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (39) @(negedge clk);
    chk("pre_rst_busy", ia.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", ia.busy, 0);
    chk("mid_rst_freq", ia.freq_cnt, 0);
    chk("mid_rst_valid", ia.cnt_valid, 0);
    chk("mid_rst_ovf", ia.overflow, 0);
    chk("mid_rst_freq_b", ib.freq_cnt, 0);
    nval = 0;
    repeat (3) begin
      @(negedge clk);
      if (ia.cnt_valid) nval++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (ia.cnt_valid || ia.busy) nval++;
    end
    chk("mid_rst_no_valid", nval, 0);
    measure(0, 0, 0, lat, busy_n, nval, cnt, ovf);
    chk("after_rst_cnt", cnt, 25);
    chk("after_rst_lat", lat, 101);
    chk("after_rst_ovf", ovf, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
